// File: rtl/filter_ctrl.sv
// filter_ctrl: frame-synchronous controller for the 3x3 line-buffer filter.
// Measures the incoming frame geometry and locks it. Filter/bypass requests
// take effect only on frame boundaries, and bypass is forced until the
// geometry is locked. Also produces a per-beat image-border flag.
//
// Ports:
//   clk, rst         video clock, asynchronous active-high reset
//   bypass_req       software request (1 = bypass, 0 = filter)
//   d_valid, hs_in   pixel beat valid, end-of-line marker (with d_valid)
//   vs_in            frame sync level, rising edge = frame boundary
//   pix_count        locked pixels per line
//   line_count       locked lines per frame
//   bypass_out       bypass control to the filter datapath
//   cfg_valid        geometry locked, filtering allowed
//   border_out       registered edge-of-image flag, qualified by border_dv
//   border_dv        d_valid delayed one cycle
//   err_line_long    line exceeded MAX_LINE (sticky until next vs rise)
//   err_geom_change  one-cycle pulse when a locked geometry is broken
//   frame_cnt        completed locked frames, wraps
module filter_ctrl #(
  parameter int MAX_LINE = 1024,
  parameter int MIN_SIZE = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bypass_req,
  input  logic             d_valid,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic [CNT_W-1:0] pix_count,
  output logic [CNT_W-1:0] line_count,
  output logic             bypass_out,
  output logic             cfg_valid,
  output logic             border_out,
  output logic             border_dv,
  output logic             err_line_long,
  output logic             err_geom_change,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LINE);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_SIZE);

  state_t           state;
  logic             vs_d;
  logic [CNT_W-1:0] x_cnt, y_cnt, ref_len;
  logic             mism;

  logic             vs_rise, line_end, long_now;
  logic [CNT_W-1:0] cur_len, ref_eff, y_eff;
  logic             mism_eff, long_eff, frame_ok, geom_same, on_border;

  assign vs_rise  = vs_in & ~vs_d;
  assign line_end = d_valid & hs_in;
  assign cur_len  = x_cnt + 1'b1;
  // Beat that pushes x_cnt to MAX_LINE without ending the line.
  assign long_now = d_valid & ~hs_in & (x_cnt >= MAX_C - 1'b1);

  // Frame-end view including a line end landing on the vs-rise cycle.
  always_comb begin
    ref_eff  = ref_len;
    y_eff    = y_cnt;
    mism_eff = mism;
    if (line_end) begin
      y_eff = y_cnt + 1'b1;
      if (y_cnt == '0) ref_eff = cur_len;
      else if (cur_len != ref_len) mism_eff = 1'b1;
    end
  end

  assign long_eff  = err_line_long | long_now;
  assign frame_ok  = ~mism_eff & ~long_eff & (ref_eff >= MIN_C) &
                     (y_eff >= MIN_C) & (ref_eff <= MAX_C);
  assign geom_same = (ref_eff == pix_count) & (y_eff == line_count);
  assign on_border = (x_cnt == '0) | (x_cnt == pix_count - 1'b1) |
                     (y_cnt == '0) | (y_cnt == line_count - 1'b1);

  // Geometry measurement counters; everything is frame-local.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d          <= 1'b0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      ref_len       <= '0;
      mism          <= 1'b0;
      err_line_long <= 1'b0;
    end else begin
      vs_d <= vs_in;
      if (vs_rise) begin
        x_cnt         <= '0;
        y_cnt         <= '0;
        ref_len       <= '0;
        mism          <= 1'b0;
        err_line_long <= 1'b0;
      end else if (d_valid) begin
        if (hs_in) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
          if (y_cnt == '0) ref_len <= cur_len;
          else if (cur_len != ref_len) mism <= 1'b1;
        end else if (x_cnt < MAX_C) begin
          x_cnt <= x_cnt + 1'b1;
        end
        if (long_now) err_line_long <= 1'b1;
      end
    end
  end

  // Lock state machine; all transitions happen on a vs rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pix_count       <= '0;
      line_count      <= '0;
      cfg_valid       <= 1'b0;
      bypass_out      <= 1'b1;
      err_geom_change <= 1'b0;
      frame_cnt       <= '0;
      border_out      <= 1'b0;
      border_dv       <= 1'b0;
    end else begin
      err_geom_change <= 1'b0;
      border_dv       <= d_valid;
      border_out      <= d_valid & (state == LOCKED) & on_border;
      if (vs_rise) begin
        case (state)
          IDLE: begin
            state      <= MEASURE;
            bypass_out <= 1'b1;
          end
          MEASURE: begin
            if (frame_ok) begin
              state      <= LOCKED;
              pix_count  <= ref_eff;
              line_count <= y_eff;
              cfg_valid  <= 1'b1;
              bypass_out <= bypass_req;
            end else begin
              bypass_out <= 1'b1;
            end
          end
          LOCKED: begin
            if (frame_ok && geom_same) begin
              frame_cnt  <= frame_cnt + 1'b1;
              bypass_out <= bypass_req;
            end else begin
              state           <= MEASURE;
              err_geom_change <= 1'b1;
              cfg_valid       <= 1'b0;
              bypass_out      <= 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            cfg_valid  <= 1'b0;
            bypass_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_filter_ctrl.sv
// tb_filter_ctrl: directed self-checking bench for filter_ctrl.
module tb_filter_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, bypass_req, d_valid, hs_in, vs_in;
  logic [CNT_W-1:0] pix_count, line_count, frame_cnt;
  logic             bypass_out, cfg_valid, border_out, border_dv;
  logic             err_line_long, err_geom_change;

  int checks = 0;
  int errors = 0;
  logic p1, p2, byp_rise;

  filter_ctrl #(.MAX_LINE(1024), .MIN_SIZE(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bypass_req(bypass_req), .d_valid(d_valid),
    .hs_in(hs_in), .vs_in(vs_in), .pix_count(pix_count),
    .line_count(line_count), .bypass_out(bypass_out), .cfg_valid(cfg_valid),
    .border_out(border_out), .border_dv(border_dv),
    .err_line_long(err_line_long), .err_geom_change(err_geom_change),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // vs pulse; p1/p2 = err_geom_change one and two cycles after the rise.
  task automatic vs_pulse();
    vs_in = 1'b1; tick(); p1 = err_geom_change; byp_rise = bypass_out;
    tick(); p2 = err_geom_change;
    vs_in = 1'b0; tick();
  endtask

  task automatic send_lines(input int w, input int h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        d_valid = 1'b1; hs_in = (x == w - 1); tick();
      end
      d_valid = 1'b0; hs_in = 1'b0; tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bypass_req = 1'b0; d_valid = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    tick(); tick();
    checks++; if (bypass_out !== 1'b1) begin errors++; $display("FAIL reset_bypass got %0b exp 1", bypass_out); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg got %0b exp 0", cfg_valid); end
    checks++; if (pix_count !== 16'd0 || line_count !== 16'd0) begin errors++; $display("FAIL reset_geom got %0d/%0d exp 0/0", pix_count, line_count); end
    checks++; if (frame_cnt !== 16'd0 || err_line_long !== 1'b0 || border_dv !== 1'b0) begin errors++; $display("FAIL reset_misc got fc=%0d ell=%0b bdv=%0b exp 0", frame_cnt, err_line_long, border_dv); end
    rst = 1'b0; tick();
  endtask

  task automatic test_lock();
    send_lines(16, 2);             // partial frame before any vs: ignored
    vs_pulse();
    checks++; if (cfg_valid !== 1'b0 || bypass_out !== 1'b1) begin errors++; $display("FAIL lock_measure got cfg=%0b byp=%0b exp 0/1", cfg_valid, bypass_out); end
    send_lines(16, 12);
    vs_pulse();
    checks++; if (pix_count !== 16'd16 || line_count !== 16'd12) begin errors++; $display("FAIL lock_geom got %0dx%0d exp 16x12", pix_count, line_count); end
    checks++; if (cfg_valid !== 1'b1 || bypass_out !== 1'b0) begin errors++; $display("FAIL lock_cfg got cfg=%0b byp=%0b exp 1/0", cfg_valid, bypass_out); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL lock_fc0 got %0d exp 0", frame_cnt); end
    send_lines(16, 12);
    vs_pulse();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL lock_fc1 got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_geom_change();
    send_lines(8, 12);
    vs_pulse();
    checks++; if (p1 !== 1'b1 || p2 !== 1'b0) begin errors++; $display("FAIL geom_pulse got %0b%0b exp 10", p1, p2); end
    checks++; if (cfg_valid !== 1'b0 || bypass_out !== 1'b1) begin errors++; $display("FAIL geom_unlock got cfg=%0b byp=%0b exp 0/1", cfg_valid, bypass_out); end
    checks++; if (pix_count !== 16'd16) begin errors++; $display("FAIL geom_hold got %0d exp 16", pix_count); end
    send_lines(8, 12);
    vs_pulse();
    checks++; if (cfg_valid !== 1'b1 || pix_count !== 16'd8 || line_count !== 16'd12) begin errors++; $display("FAIL geom_relock got cfg=%0b %0dx%0d exp 1 8x12", cfg_valid, pix_count, line_count); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL geom_fc got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_line_long();
    send_lines(8, 1);
    for (int x = 0; x < 1100; x++) begin
      d_valid = 1'b1; hs_in = (x == 1099); tick();
      if (x == 1022) begin checks++; if (err_line_long !== 1'b0) begin errors++; $display("FAIL long_early got %0b exp 0", err_line_long); end end
      if (x == 1023) begin checks++; if (err_line_long !== 1'b1) begin errors++; $display("FAIL long_set got %0b exp 1", err_line_long); end end
    end
    d_valid = 1'b0; hs_in = 1'b0; tick();
    send_lines(8, 10);
    checks++; if (err_line_long !== 1'b1) begin errors++; $display("FAIL long_sticky got %0b exp 1", err_line_long); end
    vs_pulse();
    checks++; if (err_line_long !== 1'b0) begin errors++; $display("FAIL long_clear got %0b exp 0", err_line_long); end
    checks++; if (p1 !== 1'b1 || cfg_valid !== 1'b0) begin errors++; $display("FAIL long_reject got pulse=%0b cfg=%0b exp 1/0", p1, cfg_valid); end
    send_lines(8, 12);
    vs_pulse();
    checks++; if (cfg_valid !== 1'b1 || pix_count !== 16'd8) begin errors++; $display("FAIL long_relock got cfg=%0b pix=%0d exp 1/8", cfg_valid, pix_count); end
  endtask

  task automatic test_small();
    send_lines(2, 2);
    vs_pulse();
    checks++; if (p1 !== 1'b1 || cfg_valid !== 1'b0) begin errors++; $display("FAIL small_drop got pulse=%0b cfg=%0b exp 1/0", p1, cfg_valid); end
    send_lines(2, 2);
    vs_pulse();
    checks++; if (cfg_valid !== 1'b0 || bypass_out !== 1'b1) begin errors++; $display("FAIL small_nolock got cfg=%0b byp=%0b exp 0/1", cfg_valid, bypass_out); end
    send_lines(3, 3);
    vs_pulse();
    checks++; if (cfg_valid !== 1'b1 || pix_count !== 16'd3 || line_count !== 16'd3) begin errors++; $display("FAIL small_lock got cfg=%0b %0dx%0d exp 1 3x3", cfg_valid, pix_count, line_count); end
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 3; x++) begin
        d_valid = 1'b1; hs_in = (x == 2); tick();
        checks++;
        if (border_dv !== 1'b1 || border_out !== !(x == 1 && y == 1)) begin
          errors++; $display("FAIL border_%0d_%0d got dv=%0b b=%0b exp dv=1 b=%0b", x, y, border_dv, border_out, !(x == 1 && y == 1));
        end
      end
      d_valid = 1'b0; hs_in = 1'b0; tick();
    end
    vs_pulse();
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL small_fc got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_bypass();
    send_lines(3, 1);
    bypass_req = 1'b1;
    send_lines(3, 2);
    checks++; if (bypass_out !== 1'b0) begin errors++; $display("FAIL byp_mid got %0b exp 0", bypass_out); end
    vs_pulse();
    checks++; if (byp_rise !== 1'b1) begin errors++; $display("FAIL byp_update got %0b exp 1", byp_rise); end
    checks++; if (frame_cnt !== 16'd3 || cfg_valid !== 1'b1) begin errors++; $display("FAIL byp_fc got fc=%0d cfg=%0b exp 3/1", frame_cnt, cfg_valid); end
  endtask

  // Final line end lands on the same cycle as the vs rise.
  task automatic test_simultaneous();
    send_lines(3, 2);
    d_valid = 1'b1; hs_in = 1'b0; tick(); tick();
    hs_in = 1'b1; vs_in = 1'b1; tick(); p1 = err_geom_change;
    d_valid = 1'b0; hs_in = 1'b0; tick();
    vs_in = 1'b0; tick();
    checks++; if (p1 !== 1'b0 || cfg_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got pulse=%0b cfg=%0b exp 0/1", p1, cfg_valid); end
    checks++; if (frame_cnt !== 16'd4 || line_count !== 16'd3) begin errors++; $display("FAIL simul_fc got fc=%0d lines=%0d exp 4/3", frame_cnt, line_count); end
  endtask

  task automatic test_reset_mid();
    bypass_req = 1'b0;
    send_lines(3, 1);
    d_valid = 1'b1; tick();
    #2 rst = 1'b1; #1;
    checks++; if (bypass_out !== 1'b1 || cfg_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async got byp=%0b cfg=%0b exp 1/0", bypass_out, cfg_valid); end
    checks++; if (pix_count !== 16'd0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_clr got pix=%0d fc=%0d exp 0/0", pix_count, frame_cnt); end
    d_valid = 1'b0; tick(); rst = 1'b0; tick();
    send_lines(3, 3);
    vs_pulse();
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rstmid_vs1 got %0b exp 0", cfg_valid); end
    send_lines(3, 3);
    vs_pulse();
    checks++; if (cfg_valid !== 1'b1 || pix_count !== 16'd3 || bypass_out !== 1'b0) begin errors++; $display("FAIL rstmid_relock got cfg=%0b pix=%0d byp=%0b exp 1/3/0", cfg_valid, pix_count, bypass_out); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_geom_change();
    test_line_long();
    test_small();
    test_bypass();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_ctrl.md
Name: filter_ctrl

Overview:
Frame-synchronous controller that sequences the 3x3 line-buffer filter datapath. It measures the incoming frame geometry and supplies pix_count/line_count to the filter. It applies filter/bypass requests only on frame boundaries and forces bypass until the geometry is locked. It also raises a per-pixel border flag so downstream logic can replace window edges.

Parameters:
MAX_LINE, 1024, maximum pixels per line the filter line buffers hold
MIN_SIZE, 3, minimum pixels per line and lines per frame for a valid 3x3 window
CNT_W, 16, width of geometry counters and outputs

Ports:
clk  in  1  video clock
rst  in  1  asynchronous, active-high reset
bypass_req  in  1  software request: 1 = bypass filter, 0 = filter
d_valid  in  1  pixel beat valid (dv)
hs_in  in  1  end of line; meaningful only with d_valid (marks the last pixel of the line)
vs_in  in  1  frame sync level; rising edge = frame boundary; no d_valid while high
pix_count  out  CNT_W  locked pixels per line
line_count  out  CNT_W  locked lines per frame
bypass_out  out  1  bypass control to filter datapath
cfg_valid  out  1  geometry locked, filter allowed
border_out  out  1  registered flag: current beat lies on an image edge
border_dv  out  1  d_valid delayed 1 cycle, qualifies border_out
err_line_long  out  1  line exceeded MAX_LINE, sticky until next vs rise
err_geom_change  out  1  one-cycle pulse on geometry mismatch at frame end
frame_cnt  out  CNT_W  completed frames, wraps

Behaviour:
- Reset (async, rst=1): state IDLE; all counters and outputs 0 except bypass_out=1.
- Internal counters x_cnt and y_cnt:
  - d_valid: x_cnt+1.
  - d_valid&hs_in: captures cur_len=x_cnt+1, x_cnt<=0, y_cnt+1.
  - Frame boundary (vs_in 0->1, registered edge detect) clears both.
- First line of each frame stores ref_len. A line with cur_len != ref_len sets a frame-local mismatch bit.
- Line too long: x_cnt reaching MAX_LINE with d_valid and no hs_in sets err_line_long. x_cnt saturates at MAX_LINE; the frame is invalid.
- State machine, all transitions on a vs rise only:
  - IDLE -> MEASURE on first vs rise (the partial frame is discarded).
  - MEASURE: frame is valid if no mismatch, no long line, and ref_len>=MIN_SIZE, y_cnt>=MIN_SIZE, ref_len<=MAX_LINE. If valid, latch pix_count=ref_len, line_count=y_cnt, cfg_valid=1, go to LOCKED. Otherwise stay in MEASURE.
  - LOCKED: frame must be valid and equal the latched geometry. If so, stay and frame_cnt+1. If not, pulse err_geom_change for 1 cycle, cfg_valid=0, go to MEASURE; pix_count/line_count hold their old values.
- err_line_long clears on the next vs rise, unless the new line also violates the limit.
- bypass_out:
  - In LOCKED it equals bypass_req sampled on the vs-rise cycle. It updates 1 cycle after the vs rise and is constant for the whole frame.
  - In IDLE/MEASURE it is forced to 1.
  - Leaving LOCKED forces 1 on the cycle after the vs rise.
- border_out (LOCKED only; 0 otherwise): registered on d_valid as (x_cnt==0 | x_cnt==pix_count-1 | y_cnt==0 | y_cnt==line_count-1). border_dv = d_valid registered.
- Simultaneous events:
  - vs rise with d_valid&hs_in in the same cycle: the line end is counted first, then the frame evaluated with the updated y_cnt.
  - bypass_req changes mid-frame are ignored until the next vs rise.
- rst mid-frame returns to IDLE immediately; the next full frame is re-measured.
- frame_cnt wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then 3 frames of 640x480 with bypass_req=0 -> frame 1 discarded (IDLE), frame 2 measured; after 2nd vs rise pix_count=640, line_count=480, cfg_valid=1, bypass_out=0 from frame 3; frame_cnt=1 after frame 3.
- Locked at 640x480, next frame 320x480 -> err_geom_change one-cycle pulse at vs rise, cfg_valid=0, bypass_out=1, pix_count stays 640; following 320x480 frame relocks with pix_count=320.
- Line of 1100 pixels -> err_line_long=1 when x_cnt hits 1024, frame rejected, flag clears at the vs rise that starts a compliant frame.
- Frame of 2x2 -> never locks (cfg_valid stays 0, bypass_out=1); then 3x3 frames -> locks with pix_count=3, line_count=3, border_out=1 for all beats except (1,1).
- Locked, toggle bypass_req 0->1 mid-frame -> bypass_out stays 0 until 1 cycle after the next vs rise, then 1.
- Assert rst mid-frame while LOCKED -> outputs reset asynchronously (bypass_out=1, cfg_valid=0); relock requires 2 vs rises.
